// File: rtl/reveal_engine.sv
// Minesweeper-style reveal engine: opens a target cell and, when that cell has
// no neighbouring mines, flood-fills the zero region through an internal LIFO.
// Board and cover arrays live outside; they are read combinationally through
// rd_x/rd_y, and the cover array is written through wr_*.
//
// Handshake: open_req is a single-cycle command sampled only while busy=0; a
// request seen while busy=1 is dropped. busy rises the cycle after acceptance
// and falls the cycle after the one-cycle done pulse.
module reveal_engine #(
  parameter int X_SIZE     = 16,
  parameter int Y_SIZE     = 16,
  parameter int COORD_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  open_req,
  input  logic [COORD_BITS-1:0] open_x,
  input  logic [COORD_BITS-1:0] open_y,
  output logic                  busy,
  output logic                  done,
  output logic                  hit_mine,
  output logic [8:0]            opened_cnt,
  output logic [COORD_BITS-1:0] rd_x,
  output logic [COORD_BITS-1:0] rd_y,
  input  logic [4:0]            board_val,
  input  logic [1:0]            cover_val,
  output logic                  wr_en,
  output logic [COORD_BITS-1:0] wr_x,
  output logic [COORD_BITS-1:0] wr_y,
  output logic [1:0]            wr_val,
  output logic [2:0]            dbg_state
);

  localparam int DEPTH = X_SIZE * Y_SIZE;
  localparam int AW    = $clog2(DEPTH);
  localparam int SPW   = AW + 1;
  localparam int PW    = 2 * COORD_BITS;
  localparam int NW    = COORD_BITS + 2;
  localparam logic [NW-1:0] X_LIM = NW'(X_SIZE);
  localparam logic [NW-1:0] Y_LIM = NW'(Y_SIZE);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ROOT = 3'd1,
    S_POP  = 3'd2,
    S_NBR  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                  state;
  logic [COORD_BITS-1:0]   cur_x;
  logic [COORD_BITS-1:0]   cur_y;
  logic [2:0]              nbr_idx;
  logic [SPW-1:0]          sp;
  logic [SPW-1:0]          sp_m1;
  logic [PW-1:0]           stack_mem [2**AW];

  // Offset codes: 0 = -1, 1 = 0, 2 = +1
  logic [1:0]              dxc;
  logic [1:0]              dyc;
  logic [NW-1:0]           nx_w;
  logic [NW-1:0]           ny_w;
  logic                    nbr_ok;
  logic                    cell_covered;
  logic                    cell_mine;
  logic                    cell_zero;
  logic                    push;

  assign cell_covered = (cover_val == 2'b00);
  assign cell_mine    = board_val[4];
  assign cell_zero    = (board_val[3:0] == 4'd0);
  assign sp_m1        = sp - SPW'(1);

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign wr_x      = rd_x;
  assign wr_y      = rd_y;
  assign wr_val    = 2'b10;
  assign dbg_state = state;

  // Neighbour offset table, in scan order around the current cell
  always_comb begin
    dxc = 2'd1;
    dyc = 2'd1;
    case (nbr_idx)
      3'd0: begin dxc = 2'd0; dyc = 2'd0; end
      3'd1: begin dxc = 2'd1; dyc = 2'd0; end
      3'd2: begin dxc = 2'd2; dyc = 2'd0; end
      3'd3: begin dxc = 2'd0; dyc = 2'd1; end
      3'd4: begin dxc = 2'd2; dyc = 2'd1; end
      3'd5: begin dxc = 2'd0; dyc = 2'd2; end
      3'd6: begin dxc = 2'd1; dyc = 2'd2; end
      3'd7: begin dxc = 2'd2; dyc = 2'd2; end
      default: begin dxc = 2'd1; dyc = 2'd1; end
    endcase
  end

  // Neighbour address computed two bits wider so -1 and SIZE are visible
  // before truncation; a step below zero wraps to a huge value and fails the
  // upper-limit test.
  always_comb begin
    nx_w   = {2'b00, cur_x} + {{COORD_BITS{1'b0}}, dxc} - NW'(1);
    ny_w   = {2'b00, cur_y} + {{COORD_BITS{1'b0}}, dyc} - NW'(1);
    nbr_ok = (nx_w < X_LIM) && (ny_w < Y_LIM);
  end

  // Read address, cover write strobe, mine pulse and stack push decision
  always_comb begin
    rd_x     = cur_x;
    rd_y     = cur_y;
    wr_en    = 1'b0;
    hit_mine = 1'b0;
    push     = 1'b0;
    case (state)
      S_ROOT: begin
        if (cell_covered) begin
          wr_en = 1'b1;
          if (cell_mine) hit_mine = 1'b1;
          else           push     = cell_zero;
        end
      end
      S_NBR: begin
        if (nbr_ok) begin
          rd_x = nx_w[COORD_BITS-1:0];
          rd_y = ny_w[COORD_BITS-1:0];
          if (cell_covered && !cell_mine) begin
            wr_en = 1'b1;
            push  = cell_zero;
          end
        end
      end
      default: ;
    endcase
  end

  // Stack storage; a cell is pushed in the cycle it is opened, so it can
  // never be pushed twice and DEPTH entries always suffice.
  always_ff @(posedge clk) begin
    if (push) stack_mem[sp[AW-1:0]] <= {rd_x, rd_y};
  end

  // Control FSM: state, current cell, neighbour index, stack pointer, counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cur_x      <= '0;
      cur_y      <= '0;
      nbr_idx    <= 3'd0;
      sp         <= '0;
      opened_cnt <= 9'd0;
    end else begin
      if (wr_en) opened_cnt <= opened_cnt + 9'd1;
      if (push)  sp <= sp + SPW'(1);
      case (state)
        S_IDLE: begin
          if (open_req) begin
            cur_x <= open_x;
            cur_y <= open_y;
            state <= S_ROOT;
          end
        end
        S_ROOT: state <= push ? S_POP : S_DONE;
        S_POP: begin
          if (sp == '0) begin
            state <= S_DONE;
          end else begin
            {cur_x, cur_y} <= stack_mem[sp_m1[AW-1:0]];
            sp             <= sp_m1;
            nbr_idx        <= 3'd0;
            state          <= S_NBR;
          end
        end
        S_NBR: begin
          nbr_idx <= nbr_idx + 3'd1;
          if (nbr_idx == 3'd7) state <= S_POP;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
